// File: rtl/xc_malu_ctrl.sv
// ---------------------------------------------------------------------------
// xc_malu_ctrl
//
// Issue/writeback controller for a multi-cycle ALU. One request is accepted
// at a time. The controller drives the ALU until it reports completion, and
// then writes the result back through a valid/ready handshake. A 64-bit
// result can optionally be written as two 32-bit beats to the register pair
// rd, rd|1. The ALU is flushed with pseudo-random data after every
// operation, after an abort, and after reset.
//
// Parameters
//   LFSR_SEED        non-zero start value of the flush-data LFSR
//   TIMEOUT          maximum EXEC cycles before the operation is aborted
//
// Ports
//   clock            sole clock, rising edge
//   reset            synchronous, active-high
//   req_valid/ready  issue handshake
//   req_uop          one-hot micro-op {mmul,...,div} (14 bits)
//   req_pw           one-hot pack width {pw_2,...,pw_32}
//   req_ops          operands {rs3,rs2,rs1}
//   req_rd           destination register
//   req_wide         write the full 64-bit result to rd, rd|1
//   kill             pipeline flush; aborts any in-flight operation
//   malu_valid/uop/pw/ops   command to the ALU, live only in EXEC
//   malu_flush/flush_data   one-cycle ALU clear with LFSR data
//   malu_result/ready       ALU result and completion flag
//   wb_valid/ready/rd/data  writeback handshake
//   err              one-cycle pulse on an illegal uop or a timeout
// ---------------------------------------------------------------------------
module xc_malu_ctrl #(
    parameter logic [31:0] LFSR_SEED = 32'h6A09_E667,
    parameter logic [5:0]  TIMEOUT   = 6'd40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [13:0] req_uop,
    input  logic [4:0]  req_pw,
    input  logic [95:0] req_ops,
    input  logic [4:0]  req_rd,
    input  logic        req_wide,
    input  logic        kill,
    output logic        malu_valid,
    output logic [13:0] malu_uop,
    output logic [4:0]  malu_pw,
    output logic [95:0] malu_ops,
    output logic        malu_flush,
    output logic [31:0] malu_flush_data,
    input  logic [63:0] malu_result,
    input  logic        malu_ready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_EXEC,
        S_WB_LO,
        S_WB_HI
    } state_t;

    // Right-shifting Galois form; bit 31 of the tap mask keeps the update
    // invertible, so a non-zero seed can never reach the all-zero state.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [5:0]  exec_cnt;
    logic [63:0] result;

    logic [13:0] uop_q;
    logic [4:0]  pw_q;
    logic [95:0] ops_q;
    logic [4:0]  rd_q;
    logic        wide_q;

    logic        accept;
    logic        uop_legal;
    logic        in_exec;

    function automatic logic is_onehot(input logic [13:0] v);
        return (v != '0) && ((v & (v - 14'd1)) == '0);
    endfunction

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_TAPS);
    assign uop_legal = is_onehot(req_uop);
    assign in_exec   = (state == S_EXEC);

    // Handshake outputs are gated by reset so that an operation that is
    // interrupted by reset can't issue or write back during the reset cycle.
    assign req_ready = (state == S_IDLE) && !kill && !reset;
    assign accept    = req_valid && req_ready;

    assign malu_valid      = in_exec && !reset;
    assign malu_uop        = in_exec ? uop_q : '0;
    assign malu_pw         = in_exec ? pw_q  : '0;
    assign malu_ops        = in_exec ? ops_q : '0;
    assign malu_flush      = (state == S_FLUSH) && !reset;
    assign malu_flush_data = malu_flush ? lfsr : '0;

    assign wb_valid = ((state == S_WB_LO) || (state == S_WB_HI)) && !kill && !reset;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise the states that don't assign it would infer a latch.
        wb_rd   = '0;
        wb_data = '0;
        case (state)
            S_WB_LO: begin
                wb_rd   = rd_q;
                wb_data = result[31:0];
            end
            S_WB_HI: begin
                wb_rd   = {rd_q[4:1], 1'b1};
                wb_data = result[63:32];
            end
            default: ;
        endcase
    end

    // NOTE: the request payload registers are not reset; they are only
    // observed in EXEC and in the writeback states, and they are always
    // loaded on the accept that leads there.
    always_ff @(posedge clock) begin
        if (accept && uop_legal) begin
            uop_q  <= req_uop;
            pw_q   <= req_pw;
            ops_q  <= req_ops;
            rd_q   <= req_rd;
            wide_q <= req_wide;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before this clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FLUSH;
            lfsr     <= LFSR_SEED;
            exec_cnt <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            err  <= 1'b0;
            case (state)
                S_FLUSH: state <= S_IDLE;

                S_IDLE: begin
                    if (accept) begin
                        if (uop_legal) begin
                            exec_cnt <= '0;
                            state    <= S_EXEC;
                        end else begin
                            // Illegal uop is consumed but never reaches the ALU.
                            err <= 1'b1;
                        end
                    end
                end

                S_EXEC: begin
                    if (kill) begin
                        state <= S_FLUSH;
                    end else if (malu_ready) begin
                        result <= malu_result;
                        state  <= S_WB_LO;
                    end else begin
                        exec_cnt <= exec_cnt + 6'd1;
                        if (exec_cnt == TIMEOUT - 6'd1) begin
                            err   <= 1'b1;
                            state <= S_FLUSH;
                        end
                    end
                end

                S_WB_LO: begin
                    if (kill) begin
                        state <= S_FLUSH;
                    end else if (wb_ready) begin
                        state <= wide_q ? S_WB_HI : S_FLUSH;
                    end
                end

                S_WB_HI: begin
                    if (kill || wb_ready) begin
                        state <= S_FLUSH;
                    end
                end

                default: state <= S_FLUSH;
            endcase
        end
    end

endmodule
